// File: rtl/act_feeder_pkg.sv
// Shared types and defaults for the activation-to-hlink feeder.
package act_feeder_pkg;

    localparam int unsigned MAC_NUM = 8;
    localparam int unsigned FIFO_AW = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_e;

    // Saturating increment for the 16-bit word counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/act_word_fifo.sv
// Synchronous first-word-fall-through word FIFO with registered full/empty.
module act_word_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic [CW-1:0]    w_count_nxt;
    logic             w_push;
    logic             w_pop;

    // A push into a full FIFO is allowed when a pop frees the slot in the same cycle
    assign w_pop       = pop && !r_empty;
    assign w_push      = push && (!r_full || w_pop);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = r_full;
    assign empty    = r_empty;

endmodule

// File: rtl/act_hlink_feeder.sv
// Packs activation elements into hlink words, buffers them, and broadcasts
// each word to all masked head rows once none of them is almost full.
module act_hlink_feeder #(
    parameter int unsigned HNUM       = 8,
    parameter int unsigned GBUS_DATA  = 64,
    parameter int unsigned IDATA_BIT  = 8,
    parameter int unsigned MAC_NUM    = GBUS_DATA / IDATA_BIT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [HNUM-1:0]           cfg_head_mask,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [IDATA_BIT-1:0]      s_data,
    input  logic                      s_last,
    input  logic [HNUM-1:0]           abuf_almost_full,
    output logic [HNUM*GBUS_DATA-1:0] hlink_wdata,
    output logic [HNUM-1:0]           hlink_wen,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               words_sent
);

    import act_feeder_pkg::*;

    localparam int unsigned LANE_W = (MAC_NUM > 1) ? $clog2(MAC_NUM) : 1;

    feeder_state_e              r_state;
    logic [HNUM-1:0]            r_mask;
    logic [LANE_W-1:0]          r_lane;
    logic [GBUS_DATA-1:0]       r_pack;
    logic [HNUM-1:0]            r_wen;
    logic [HNUM*GBUS_DATA-1:0]  r_wdata;
    logic                       r_busy;
    logic                       r_done;
    logic [15:0]                r_words;

    logic                       w_hs;
    logic                       w_lane_last;
    logic                       w_push;
    logic                       w_pop;
    logic [GBUS_DATA-1:0]       w_elem_word;
    logic [GBUS_DATA-1:0]       w_push_word;
    logic [GBUS_DATA-1:0]       w_fifo_rd;
    logic                       w_fifo_full;
    logic                       w_fifo_empty;

    assign s_ready     = (r_state == ST_PACK) && !w_fifo_full;
    assign w_hs        = s_valid && s_ready;
    assign w_lane_last = (r_lane == LANE_W'(MAC_NUM - 1));
    assign w_push      = w_hs && (w_lane_last || s_last);
    assign w_elem_word = GBUS_DATA'(s_data) << (r_lane * IDATA_BIT);
    assign w_push_word = r_pack | w_elem_word;
    // Broadcast is all-or-nothing: any masked row near full holds every row
    assign w_pop       = !w_fifo_empty && ((abuf_almost_full & r_mask) == '0);

    act_word_fifo #(
        .WIDTH (GBUS_DATA),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_word),
        .pop       (w_pop),
        .pop_data  (w_fifo_rd),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // Lane packer; unwritten lanes stay zero because the register clears on push
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane <= '0;
            r_pack <= '0;
        end else if (w_hs) begin
            if (w_push) begin
                r_lane <= '0;
                r_pack <= '0;
            end else begin
                r_lane <= r_lane + LANE_W'(1);
                r_pack <= w_push_word;
            end
        end
    end

    // Output stage: popped word appears on masked rows the following cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen   <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= w_pop ? r_mask : '0;
            for (int h = 0; h < int'(HNUM); h++) begin
                r_wdata[h*GBUS_DATA +: GBUS_DATA] <= (w_pop && r_mask[h]) ? w_fifo_rd : '0;
            end
        end
    end

    // Control FSM with registered busy/done and the word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_words <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_pop) begin
                r_words <= sat_inc16(r_words);
            end
            case (r_state)
                ST_IDLE: begin
                    if (start && (cfg_head_mask != '0)) begin
                        r_mask  <= cfg_head_mask;
                        r_words <= '0;
                        r_state <= ST_PACK;
                        r_busy  <= 1'b1;
                    end
                end
                ST_PACK: begin
                    if (w_hs && s_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Empty here means the last pop has already been emitted
                    if (w_fifo_empty) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign hlink_wen   = r_wen;
    assign hlink_wdata = r_wdata;
    assign busy        = r_busy;
    assign done        = r_done;
    assign words_sent  = r_words;

endmodule

// File: tb/tb_act_hlink_feeder.sv
// Randomized bench for act_hlink_feeder checked against a chunk-and-broadcast reference model.
module tb_act_hlink_feeder;

    localparam int HNUM  = 8;
    localparam int GB    = 64;
    localparam int IB    = 8;
    localparam int MN    = GB / IB;
    localparam int DEPTH = 4;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [HNUM-1:0]      cfg_head_mask;
    logic                 s_valid;
    logic                 s_ready;
    logic [IB-1:0]        s_data;
    logic                 s_last;
    logic [HNUM-1:0]      abuf_almost_full;
    logic [HNUM*GB-1:0]   hlink_wdata;
    logic [HNUM-1:0]      hlink_wen;
    logic                 busy;
    logic                 done;
    logic [15:0]          words_sent;

    act_hlink_feeder #(
        .HNUM (HNUM), .GBUS_DATA (GB), .IDATA_BIT (IB), .MAC_NUM (MN), .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .cfg_head_mask (cfg_head_mask),
        .s_valid (s_valid), .s_ready (s_ready), .s_data (s_data), .s_last (s_last),
        .abuf_almost_full (abuf_almost_full), .hlink_wdata (hlink_wdata),
        .hlink_wen (hlink_wen), .busy (busy), .done (done), .words_sent (words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ce = 0;
    int ne = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Emission log and stall-rule watcher
    logic [HNUM-1:0]    af_edge;
    logic [HNUM-1:0]    ev_wen[$];
    logic [HNUM*GB-1:0] ev_data[$];
    int                 ev_cyc[$];
    int                 stall_viol = 0;
    always @(posedge clk) af_edge <= abuf_almost_full;
    always @(negedge clk) begin
        if (hlink_wen != '0) begin
            ev_wen.push_back(hlink_wen);
            ev_data.push_back(hlink_wdata);
            ev_cyc.push_back(cyc);
            if ((af_edge & hlink_wen) != '0) stall_viol++;
        end
    end

    // Reference model: elements chunked into MN-lane words, last chunk zero-padded
    logic [IB-1:0] elems[$];
    logic [GB-1:0] exp_q[$];
    function automatic void model_words();
        exp_q.delete();
        for (int i = 0; i < elems.size(); i += MN) begin
            logic [GB-1:0] w;
            w = '0;
            for (int k = 0; k < MN && (i + k) < elems.size(); k++) w[k*IB +: IB] = elems[i+k];
            exp_q.push_back(w);
        end
    endfunction

    function automatic logic [HNUM*GB-1:0] bcast(input logic [HNUM-1:0] m, input logic [GB-1:0] w);
        logic [HNUM*GB-1:0] r;
        r = '0;
        for (int h = 0; h < HNUM; h++) if (m[h]) r[h*GB +: GB] = w;
        return r;
    endfunction

    function automatic void rand_elems(input int n);
        elems.delete();
        for (int i = 0; i < n; i++) elems.push_back(IB'($urandom));
    endfunction

    task automatic do_start(input logic [HNUM-1:0] m);
        @(negedge clk);
        start = 1'b1;
        cfg_head_mask = m;
        @(negedge clk);
        start = 1'b0;
        cfg_head_mask = HNUM'($urandom);
    endtask

    task automatic drive_stream(input int from, input int to, input int gap_pct, input bit af_rand,
                                input int budget, output int acc, output int last_hs);
        int idx;
        idx = from;
        last_hs = -1;
        for (int n = 0; n < budget && idx < to; n++) begin
            @(negedge clk);
            if (af_rand) abuf_almost_full = ($urandom_range(3) == 0) ? HNUM'($urandom) : '0;
            if (int'($urandom_range(99)) >= gap_pct) begin
                s_valid = 1'b1;
                s_data  = elems[idx];
                s_last  = (idx == elems.size() - 1);
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                s_data  = '0;
            end
            if (s_valid && s_ready) begin
                if (s_last) last_hs = cyc;
                idx++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        acc = idx;
    endtask

    task automatic wait_done(input bit af_rand, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            abuf_almost_full = (af_rand && $urandom_range(3) == 0) ? HNUM'($urandom) : '0;
        end
        abuf_almost_full = '0;
    endtask

    int last_ws = 0;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        ce++; if (busy !== 1'b0)          begin ne++; $display("FAIL reset_busy got %b want 0", busy); end
        ce++; if (done !== 1'b0)          begin ne++; $display("FAIL reset_done got %b want 0", done); end
        ce++; if (s_ready !== 1'b0)       begin ne++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
        ce++; if (hlink_wen !== '0)       begin ne++; $display("FAIL reset_wen got %h want 0", hlink_wen); end
        ce++; if (hlink_wdata !== '0)     begin ne++; $display("FAIL reset_wdata got %h want 0", hlink_wdata); end
        ce++; if (words_sent !== 16'd0)   begin ne++; $display("FAIL reset_words got %0d want 0", words_sent); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int base, acc, hs; bit ok;
        logic [HNUM-1:0] m;
        m = 8'h05;
        elems.delete();
        for (int i = 0; i < 16; i++) elems.push_back(IB'(i + 1));
        model_words();
        base = ev_wen.size();
        do_start(m);
        drive_stream(0, 16, 0, 1'b0, 100, acc, hs);
        wait_done(1'b0, 50, ok);
        ce++; if (!ok) begin ne++; $display("FAIL basic_done_timeout got 0 want 1"); end
        @(negedge clk);
        ce++; if (done !== 1'b0 || busy !== 1'b0) begin ne++; $display("FAIL basic_done_width got done %b busy %b want 0 0", done, busy); end
        ce++; if (ev_wen.size() - base !== exp_q.size()) begin ne++; $display("FAIL basic_count got %0d want %0d", ev_wen.size() - base, exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            ce++;
            if (ev_wen[base+i] !== m || ev_data[base+i] !== bcast(m, exp_q[i])) begin
                ne++; $display("FAIL basic_word%0d got wen %h data %h want wen %h data %h", i, ev_wen[base+i], ev_data[base+i], m, bcast(m, exp_q[i]));
            end
        end
        ce++; if (words_sent !== 16'(exp_q.size())) begin ne++; $display("FAIL basic_words got %0d want %0d", words_sent, exp_q.size()); end
        last_ws = exp_q.size();
    endtask

    task automatic test_short_latency();
        int base, acc, hs; bit ok;
        logic [HNUM-1:0] m;
        m = 8'h05;
        elems.delete();
        elems.push_back(8'hAA); elems.push_back(8'hBB); elems.push_back(8'hCC);
        model_words();
        base = ev_wen.size();
        do_start(m);
        drive_stream(0, 3, 0, 1'b0, 50, acc, hs);
        wait_done(1'b0, 50, ok);
        ce++; if (!ok) begin ne++; $display("FAIL short_done_timeout got 0 want 1"); end
        ce++; if (ev_wen.size() - base !== 1) begin ne++; $display("FAIL short_count got %0d want 1", ev_wen.size() - base); end
        else begin
            ce++; if (ev_data[base] !== bcast(m, exp_q[0])) begin ne++; $display("FAIL short_data got %h want %h", ev_data[base], bcast(m, exp_q[0])); end
            ce++; if (ev_cyc[base] - hs !== 2) begin ne++; $display("FAIL short_latency got %0d want 2", ev_cyc[base] - hs); end
        end
        last_ws = exp_q.size();
    endtask

    task automatic test_backpressure();
        int base, acc, hs, sv; bit ok;
        logic [HNUM-1:0] m;
        m = 8'h05;
        rand_elems(48);
        model_words();
        base = ev_wen.size();
        sv = stall_viol;
        abuf_almost_full = 8'h04;
        do_start(m);
        drive_stream(0, 48, 0, 1'b0, 60, acc, hs);
        ce++; if (acc !== DEPTH * MN) begin ne++; $display("FAIL bp_accepted got %0d want %0d", acc, DEPTH * MN); end
        ce++; if (ev_wen.size() !== base) begin ne++; $display("FAIL bp_no_emit got %0d want 0", ev_wen.size() - base); end
        ce++; if (s_ready !== 1'b0) begin ne++; $display("FAIL bp_s_ready got %b want 0", s_ready); end
        abuf_almost_full = '0;
        drive_stream(acc, 48, 0, 1'b0, 200, acc, hs);
        wait_done(1'b0, 100, ok);
        ce++; if (!ok) begin ne++; $display("FAIL bp_done_timeout got 0 want 1"); end
        ce++; if (ev_wen.size() - base !== exp_q.size()) begin ne++; $display("FAIL bp_count got %0d want %0d", ev_wen.size() - base, exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                ce++;
                if (ev_wen[base+i] !== m || ev_data[base+i] !== bcast(m, exp_q[i])) begin
                    ne++; $display("FAIL bp_word%0d got wen %h data %h want wen %h data %h", i, ev_wen[base+i], ev_data[base+i], m, bcast(m, exp_q[i]));
                end
            end
            for (int i = 0; i < DEPTH - 1; i++) begin
                ce++; if (ev_cyc[base+i+1] - ev_cyc[base+i] !== 1) begin ne++; $display("FAIL bp_rate%0d got gap %0d want 1", i, ev_cyc[base+i+1] - ev_cyc[base+i]); end
            end
        end
        ce++; if (stall_viol !== sv) begin ne++; $display("FAIL bp_stall_rule got %0d want %0d", stall_viol, sv); end
        last_ws = exp_q.size();
    endtask

    task automatic test_unmasked_af();
        int base, acc, hs, last; bit ok;
        logic [HNUM-1:0] m;
        m = 8'h05;
        rand_elems(20);
        model_words();
        base = ev_wen.size();
        abuf_almost_full = 8'h08;
        do_start(m);
        drive_stream(0, 20, 0, 1'b0, 60, acc, hs);
        wait_done(1'b0, 50, ok);
        ce++; if (!ok) begin ne++; $display("FAIL unm_done_timeout got 0 want 1"); end
        ce++; if (ev_wen.size() - base !== exp_q.size()) begin ne++; $display("FAIL unm_count got %0d want %0d", ev_wen.size() - base, exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                ce++;
                if (ev_wen[base+i] !== m || ev_data[base+i] !== bcast(m, exp_q[i])) begin
                    ne++; $display("FAIL unm_word%0d got wen %h data %h want wen %h data %h", i, ev_wen[base+i], ev_data[base+i], m, bcast(m, exp_q[i]));
                end
            end
            last = ev_cyc[base + exp_q.size() - 1];
            ce++; if (last - hs !== 2) begin ne++; $display("FAIL unm_latency got %0d want 2", last - hs); end
        end
        last_ws = exp_q.size();
    endtask

    task automatic test_reset_mid();
        int base, acc, hs; bit ok;
        logic [HNUM-1:0] m;
        m = HNUM'($urandom_range(255, 1));
        rand_elems(40);
        base = ev_wen.size();
        do_start(m);
        drive_stream(0, 40, 0, 1'b0, 100, acc, hs);
        ce++; if (ev_wen.size() - base !== 4 || busy !== 1'b1) begin ne++; $display("FAIL rmid_pre got words %0d busy %b want 4 1", ev_wen.size() - base, busy); end
        rst = 1'b1;
        @(negedge clk);
        ce++; if (busy !== 1'b0 || hlink_wen !== '0) begin ne++; $display("FAIL rmid_after got busy %b wen %h want 0 0", busy, hlink_wen); end
        ce++; if (words_sent !== 16'd0) begin ne++; $display("FAIL rmid_words got %0d want 0", words_sent); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        ce++; if (ev_wen.size() - base !== 4) begin ne++; $display("FAIL rmid_discard got %0d want 4", ev_wen.size() - base); end
        m = HNUM'($urandom_range(255, 1));
        rand_elems(13);
        model_words();
        base = ev_wen.size();
        do_start(m);
        drive_stream(0, 13, 20, 1'b0, 100, acc, hs);
        wait_done(1'b0, 50, ok);
        ce++; if (!ok) begin ne++; $display("FAIL rmid_done_timeout got 0 want 1"); end
        ce++; if (ev_wen.size() - base !== exp_q.size()) begin ne++; $display("FAIL rmid_count got %0d want %0d", ev_wen.size() - base, exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            ce++;
            if (ev_wen[base+i] !== m || ev_data[base+i] !== bcast(m, exp_q[i])) begin
                ne++; $display("FAIL rmid_word%0d got wen %h data %h want wen %h data %h", i, ev_wen[base+i], ev_data[base+i], m, bcast(m, exp_q[i]));
            end
        end
        ce++; if (words_sent !== 16'(exp_q.size())) begin ne++; $display("FAIL rmid_words_new got %0d want %0d", words_sent, exp_q.size()); end
        last_ws = exp_q.size();
    endtask

    task automatic test_ignored_starts();
        int base, acc, hs; bit ok;
        logic [HNUM-1:0] m;
        do_start('0);
        ce++; if (busy !== 1'b0 || words_sent !== 16'(last_ws)) begin ne++; $display("FAIL ign_mask0 got busy %b words %0d want 0 %0d", busy, words_sent, last_ws); end
        m = 8'h05;
        rand_elems(24);
        model_words();
        base = ev_wen.size();
        do_start(m);
        drive_stream(0, 12, 0, 1'b0, 60, acc, hs);
        start = 1'b1;
        cfg_head_mask = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        ce++; if (busy !== 1'b1 || s_ready !== 1'b1 || words_sent !== 16'd1) begin
            ne++; $display("FAIL ign_busy got busy %b ready %b words %0d want 1 1 1", busy, s_ready, words_sent);
        end
        drive_stream(12, 24, 0, 1'b0, 60, acc, hs);
        wait_done(1'b0, 50, ok);
        ce++; if (!ok) begin ne++; $display("FAIL ign_done_timeout got 0 want 1"); end
        ce++; if (ev_wen.size() - base !== exp_q.size()) begin ne++; $display("FAIL ign_count got %0d want %0d", ev_wen.size() - base, exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            ce++;
            if (ev_wen[base+i] !== m || ev_data[base+i] !== bcast(m, exp_q[i])) begin
                ne++; $display("FAIL ign_word%0d got wen %h data %h want wen %h data %h", i, ev_wen[base+i], ev_data[base+i], m, bcast(m, exp_q[i]));
            end
        end
        ce++; if (words_sent !== 16'(exp_q.size())) begin ne++; $display("FAIL ign_words got %0d want %0d", words_sent, exp_q.size()); end
        last_ws = exp_q.size();
    endtask

    task automatic test_random();
        int base, acc, hs, sv, n; bit ok;
        logic [HNUM-1:0] m;
        for (int it = 0; it < 6; it++) begin
            m = HNUM'($urandom_range(255, 1));
            n = int'($urandom_range(40, 1));
            rand_elems(n);
            model_words();
            base = ev_wen.size();
            sv = stall_viol;
            do_start(m);
            drive_stream(0, n, 30, 1'b1, 2000, acc, hs);
            wait_done(1'b1, 2000, ok);
            ce++; if (acc !== n || !ok) begin ne++; $display("FAIL rnd%0d_progress got acc %0d done %b want %0d 1", it, acc, ok, n); end
            ce++; if (ev_wen.size() - base !== exp_q.size()) begin ne++; $display("FAIL rnd%0d_count got %0d want %0d", it, ev_wen.size() - base, exp_q.size()); end
            else for (int i = 0; i < exp_q.size(); i++) begin
                ce++;
                if (ev_wen[base+i] !== m || ev_data[base+i] !== bcast(m, exp_q[i])) begin
                    ne++; $display("FAIL rnd%0d_word%0d got wen %h data %h want wen %h data %h", it, i, ev_wen[base+i], ev_data[base+i], m, bcast(m, exp_q[i]));
                end
            end
            ce++; if (words_sent !== 16'(exp_q.size())) begin ne++; $display("FAIL rnd%0d_words got %0d want %0d", it, words_sent, exp_q.size()); end
            ce++; if (stall_viol !== sv) begin ne++; $display("FAIL rnd%0d_stall_rule got %0d want %0d", it, stall_viol, sv); end
            last_ws = exp_q.size();
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_head_mask = '0;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        abuf_almost_full = '0;
        test_reset();
        test_basic();
        test_short_latency();
        test_backpressure();
        test_unmasked_af();
        test_reset_mid();
        test_ignored_starts();
        test_random();
        $display("CHECKS %0d ERRORS %0d", ce, ne);
        $finish;
    end

endmodule

// File: doc/act_hlink_feeder.md
ACT_HLINK_FEEDER -- requirements
Module: act_hlink_feeder

Interface
REQ-001 Parameter HNUM, default 8: number of head rows fed.
REQ-002 Parameter GBUS_DATA, default 64: hlink word width.
REQ-003 Parameter IDATA_BIT, default 8: activation element width.
REQ-004 Parameter MAC_NUM, default GBUS_DATA/IDATA_BIT: lanes per word.
REQ-005 Parameter FIFO_DEPTH, default 4: word FIFO depth, power of two, at least 2.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  in  1  sole clock; all state updates on the rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 start  in  1  one-cycle pulse that begins a transfer.
REQ-010 cfg_head_mask  in  HNUM  target rows; sampled when start is accepted.
REQ-011 s_valid  in  1  activation element valid.
REQ-012 s_ready  out  1  element accepted when s_valid and s_ready are both high.
REQ-013 s_data  in  IDATA_BIT  activation element.
REQ-014 s_last  in  1  marks the final element of the transfer.
REQ-015 abuf_almost_full  in  HNUM  column-0 activation buffer almost-full flag per row.
REQ-016 hlink_wdata  out  HNUM*GBUS_DATA  packed word per row; row h occupies bits [h*GBUS_DATA +: GBUS_DATA].
REQ-017 hlink_wen  out  HNUM  per-row write strobe.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle completion pulse.
REQ-020 words_sent  out  16  count of words emitted in the current or last transfer.

Function
REQ-021 States: IDLE, PACK, DRAIN, DONE.
REQ-022 IDLE->PACK when start=1 and cfg_head_mask!=0; the mask is latched and words_sent is cleared. A start with mask 0 is ignored.
REQ-023 A start pulse outside IDLE is ignored.
REQ-024 s_ready = (state==PACK) and FIFO not full.
REQ-025 Packing: the k-th accepted element of a word goes to bits [k*IDATA_BIT +: IDATA_BIT], starting at lane 0.
REQ-026 A word is pushed in the handshake cycle of lane MAC_NUM-1, or of any element with s_last=1; lanes not yet written are zero. The lane counter then returns to 0.
REQ-027 PACK->DRAIN on the handshake cycle with s_last=1.
REQ-028 Pop/emit: when the FIFO is non-empty and (abuf_almost_full & latched mask)==0, one word is popped.
REQ-029 In the cycle after a pop, each masked row h has hlink_wen[h]=1 and carries the popped word on its hlink_wdata slice.
REQ-030 Unmasked rows, and all rows in non-emit cycles, drive hlink_wen=0 and hlink_wdata=0.
REQ-031 Latency: a word completed in handshake cycle C appears on hlink in cycle C+2 when there is no backpressure.
REQ-032 A push and a pop in the same cycle are both legal when the FIFO is full; occupancy is then unchanged.
REQ-033 Sustained throughput is one word per cycle.
REQ-034 Any masked almost_full bit stalls all rows; partial broadcast is never performed.
REQ-035 words_sent increments once per pop and saturates at 0xFFFF.
REQ-036 DRAIN->DONE in the cycle after the FIFO is empty and the final hlink_wen has been issued.
REQ-037 done=1 for exactly the single cycle spent in DONE; the next state is IDLE.

Reset
REQ-038 While rst=1, the next state is IDLE; the FIFO pointers, lane counter, packing register, latched mask and words_sent are cleared.
REQ-039 While rst=1, s_ready, hlink_wen, hlink_wdata, busy and done are 0 after the next edge.
REQ-040 Reset mid-transfer discards buffered words with no further hlink_wen; outputs are 0 in the cycle after the reset edge.

Structure
REQ-041 The state enum and the localparams MAC_NUM and FIFO_AW belong in shared package act_feeder_pkg.
REQ-042 The word FIFO is sub-module act_word_fifo (synchronous, registered occupancy, full/empty outputs); the packer, FSM and output stage live in the top module.

Verification
REQ-043 Setup: MAC_NUM=8, mask=8'h05. Stream 16 elements 0x01..0x10, last on the 16th, no backpressure -> rows 0 and 2 receive 0x0807060504030201 then 0x100F0E0D0C0B0A09; words_sent=2; done is one cycle.
REQ-044 Stream 3 elements 0xAA,0xBB,0xCC with s_last on the third -> one word 0x0000000000CCBBAA; the first hlink_wen occurs 2 cycles after the third handshake.
REQ-045 Hold abuf_almost_full[2]=1 with mask 8'h05 while streaming 48 elements -> no hlink_wen; s_ready falls after 4 words are buffered. Release -> 6 words in order, one per cycle.
REQ-046 Set abuf_almost_full[3]=1 (unmasked row) -> no stall; row 3 sees only zeros.
REQ-047 Assert rst after 5 words pushed mid-DRAIN -> next cycle busy=0 and hlink_wen=0; a new start yields correct data with words_sent restarting at 0.
REQ-048 Start with mask 0, and start while busy -> both ignored; the FSM and counters are unchanged.
